control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 93 +++++++++
 tb/tb_control_fsm.sv | 126 ++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle datapath controller (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define ILLEGAL_TRAP_EN to route illegal opcodes through a one-cycle TRAP state.
module control_fsm #(
    parameter int OPW  = 5,
    parameter int ALUW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  OPCODE,
    input  logic [ALUW-1:0] ALUOP,
    input  logic            INSTR_VALID,
    input  logic            MEM_READY,
    input  logic            ZERO,
    output logic            IR_LOAD,
    output logic [ALUW-1:0] ALUSignal,
    output logic            OpbSelect,
    output logic            R2S,
    output logic            WE,
    output logic            RE,
    output logic            SelectMem,
    output logic            RWrite,
    output logic            Branch,
    output logic [2:0]      STATE,
    output logic            ILLEGAL
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE, EXEC, MEM, WB, TRAP} state_t;
    state_t          state_q, state_d;
    logic [OPW-1:0]  op_q;
    logic [ALUW-1:0] aop_q;
    logic            is_r, is_ld, is_st, is_beq, is_addi, legal, exec_ph;
    assign is_r    = op_q == OPW'(0);
    assign is_ld   = op_q == OPW'(1);
    assign is_st   = op_q == OPW'(2);
    assign is_beq  = op_q == OPW'(3);
    assign is_addi = op_q == OPW'(4);
    assign legal   = op_q < OPW'(5);
    assign STATE   = state_q;
    // ALU controls stay stable from EXEC through writeback
    assign exec_ph   = state_q == EXEC || state_q == MEM || state_q == WB;
    assign ALUSignal = !exec_ph ? '0 : is_r ? aop_q : is_beq ? ALUW'(1) : '0;
    assign OpbSelect = exec_ph & (is_ld | is_st | is_addi);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            aop_q   <= '0;
        end else begin
            state_q <= state_d;
            if (IR_LOAD) begin
                op_q  <= OPCODE;
                aop_q <= ALUOP;
            end
        end
    end
    always_comb begin
        state_d   = FETCH;
        IR_LOAD   = 1'b0;
        R2S       = 1'b0;
        WE        = 1'b0;
        RE        = 1'b0;
        SelectMem = 1'b0;
        RWrite    = 1'b0;
        Branch    = 1'b0;
        ILLEGAL   = 1'b0;
        case (state_q)
            FETCH: begin
                IR_LOAD = INSTR_VALID & ~rst;
                state_d = INSTR_VALID ? DECODE : FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            DECODE: state_d = legal ? EXEC : TRAP;
            TRAP:   ILLEGAL = 1'b1;
`else
            DECODE: state_d = legal ? EXEC : FETCH;
`endif
            EXEC: begin
                Branch  = is_beq & ZERO;
                state_d = (is_ld | is_st) ? MEM : is_beq ? FETCH : WB;
            end
            MEM: begin
                RE      = is_ld;
                WE      = is_st;
                R2S     = is_st;
                state_d = !MEM_READY ? MEM : is_ld ? WB : FETCH;
            end
            WB: begin
                RWrite    = 1'b1;
                SelectMem = is_ld;
            end
            default: state_d = FETCH;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed checks of control_fsm outputs per cycle.
module tb_control_fsm;
    logic       clk = 0, rst = 1;
    logic [4:0] OPCODE = '0;
    logic [2:0] ALUOP = '0;
    logic       INSTR_VALID = 0, MEM_READY = 0, ZERO = 0;
    logic       IR_LOAD, OpbSelect, R2S, WE, RE, SelectMem, RWrite, Branch, ILLEGAL;
    logic [2:0] ALUSignal, STATE;
    logic [14:0] obs;
    int checks = 0, errors = 0;

    control_fsm dut (
        .clk(clk), .rst(rst), .OPCODE(OPCODE), .ALUOP(ALUOP),
        .INSTR_VALID(INSTR_VALID), .MEM_READY(MEM_READY), .ZERO(ZERO),
        .IR_LOAD(IR_LOAD), .ALUSignal(ALUSignal), .OpbSelect(OpbSelect),
        .R2S(R2S), .WE(WE), .RE(RE), .SelectMem(SelectMem), .RWrite(RWrite),
        .Branch(Branch), .STATE(STATE), .ILLEGAL(ILLEGAL)
    );

    always #5 clk = ~clk;
    assign obs = {IR_LOAD, ALUSignal, OpbSelect, R2S, WE, RE, SelectMem, RWrite, Branch, ILLEGAL, STATE};

    // ir, alu, opb, r2s, we, re, selmem, rwrite, branch, illegal, state
    function automatic logic [14:0] ev(logic ir, logic [2:0] alu, logic opb, logic r2s, logic we,
                                       logic re, logic sm, logic rw, logic br, logic il, logic [2:0] st);
        return {ir, alu, opb, r2s, we, re, sm, rw, br, il, st};
    endfunction

    task automatic chk(input string tag, input logic [14:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [4:0] op, input logic [2:0] aop, input string tag);
        OPCODE = op; ALUOP = aop; INSTR_VALID = 1;
        #1 chk(tag, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        go();
        INSTR_VALID = 0; OPCODE = 5'd3;
        #1 chk({tag, "_dec"}, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    initial begin
        INSTR_VALID = 1;
        #3 chk("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        go(); go();
        rst = 0;
        // R-type, ALUOP=5
        accept(5'd0, 3'b101, "r_acc");
        go(); chk("r_exec", ev(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        go(); chk("r_wb",   ev(0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 4));
        go(); chk("r_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // idle with toggling opcode
        for (int i = 0; i < 5; i++) begin
            OPCODE = 5'(i * 7); ALUOP = 3'(i);
            go(); chk("idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        // LDR with two wait cycles
        accept(5'd1, 3'd7, "ld_acc");
        MEM_READY = 1;
        go(); chk("ld_exec", ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        MEM_READY = 0;
        go(); chk("ld_mem1", ev(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 3));
        go(); chk("ld_mem2", ev(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 3));
        go(); chk("ld_mem3", ev(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 3));
        MEM_READY = 1;
        go(); chk("ld_wb", ev(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 4));
        MEM_READY = 0;
        go(); chk("ld_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // BEQ taken, ZERO live in EXEC only
        ZERO = 1;
        accept(5'd3, 3'd6, "beq_acc");
        go(); chk("beq_exec_z1", ev(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        ZERO = 0;
        #1 chk("beq_exec_z0", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        ZERO = 1;
        go(); chk("beq_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ZERO = 0;
        accept(5'd3, 3'd0, "beqnt_acc");
        go(); chk("beqnt_exec", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        go(); chk("beqnt_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ADDI
        accept(5'd4, 3'd6, "addi_acc");
        go(); chk("addi_exec", ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        go(); chk("addi_wb",   ev(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4));
        go(); chk("addi_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // STR, ready immediately
        MEM_READY = 1;
        accept(5'd2, 3'd5, "st_acc");
        go(); chk("st_exec", ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        go(); chk("st_mem",  ev(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3));
        go(); chk("st_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // STR, asynchronous reset while stalled in MEM
        MEM_READY = 0;
        accept(5'd2, 3'd5, "str_acc");
        go(); go(); chk("str_mem", ev(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3));
        #2 rst = 1;
        #1 chk("str_rst", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        go();
        rst = 0;
        accept(5'd0, 3'd2, "post_rst_acc");
        go(); chk("post_rst_exec", ev(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        go(); chk("post_rst_wb",   ev(0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 4));
        go(); chk("post_rst_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // illegal opcodes
        accept(5'b11111, 3'd1, "ill_acc");
`ifdef ILLEGAL_TRAP_EN
        go(); chk("ill_trap", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
`endif
        go(); chk("ill_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        accept(5'd5, 3'd1, "ill5_acc");
`ifdef ILLEGAL_TRAP_EN
        go(); chk("ill5_trap", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
`endif
        go(); chk("ill5_fetch", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
